// File: rtl/jtag_dr_chain_if.sv
// Signal bundle between the JTAG TAP / core logic and the data-register chain.
// The TAP side (IR, SO, SHIFT_EN, LOAD_CHAIN, STORE_CHAIN, SI) and the core side
// (CAPTURE_DATA, UPDATE_DATA, UPDATE_VALID, LEN_ERR) travel together so the
// chain can be dropped in with a single port.
interface jtag_dr_chain_if #(
   parameter int IR_WIDTH   = 6,
   parameter int USER_WIDTH = 16
);
   logic [IR_WIDTH-1:0]   IR;
   logic                  SO;
   logic                  SHIFT_EN;
   logic                  LOAD_CHAIN;
   logic                  STORE_CHAIN;
   logic                  SI;
   logic [USER_WIDTH-1:0] CAPTURE_DATA;
   logic [USER_WIDTH-1:0] UPDATE_DATA;
   logic                  UPDATE_VALID;
   logic                  LEN_ERR;

   // TAP controller plus core logic: drives the scan controls, reads results
   modport master (
      output IR, SO, SHIFT_EN, LOAD_CHAIN, STORE_CHAIN, CAPTURE_DATA,
      input  SI, UPDATE_DATA, UPDATE_VALID, LEN_ERR
   );

   // Data-register chain
   modport slave (
      input  IR, SO, SHIFT_EN, LOAD_CHAIN, STORE_CHAIN, CAPTURE_DATA,
      output SI, UPDATE_DATA, UPDATE_VALID, LEN_ERR
   );
endinterface

// File: rtl/jtag_dr_chain.sv
// JTAG data-register chain sitting directly behind the TAP controller.
// Holds BYPASS (1 bit), optional IDCODE (32 bits) and a USER register with a
// parallel capture/update path to core logic and a sticky shift-length error.
// Optional feature: define JTAG_IDCODE_EN to build the IDCODE register; when it
// is undefined the IDCODE opcode simply selects the bypass flop.
module jtag_dr_chain #(
   parameter int                  IR_WIDTH   = 6,
   parameter int                  USER_WIDTH = 16,
   parameter int                  CNT_WIDTH  = 8,
   parameter logic [IR_WIDTH-1:0] IDCODE_OP  = 6'h01,
   parameter logic [IR_WIDTH-1:0] USER_OP    = 6'h02,
   parameter logic [31:0]         IDCODE_VAL = 32'h0000_0001
) (
   input  logic           TCK,
   input  logic           TRST_N,
   jtag_dr_chain_if.slave dr
);

   typedef enum logic [1:0] {
      SEL_BYPASS = 2'd0,
      SEL_IDCODE = 2'd1,
      SEL_USER   = 2'd2
   } dr_sel_t;

   dr_sel_t               sel;
   dr_sel_t               ir_sel;
   logic                  bypass_sr;
   logic [USER_WIDTH-1:0] user_sr;
   logic [CNT_WIDTH-1:0]  bit_cnt;
   logic [USER_WIDTH-1:0] update_data;
   logic                  update_valid;
   logic                  len_err;
   logic                  si;
   logic                  do_capture;
   logic                  do_shift;
   logic                  do_update;

   // Capture wins over shift and update whenever they overlap
   assign do_capture = dr.LOAD_CHAIN;
   assign do_shift   = dr.SHIFT_EN & ~dr.LOAD_CHAIN;
   assign do_update  = dr.STORE_CHAIN & ~dr.LOAD_CHAIN;

   // Decode the instruction into a register select; unknown opcodes fall back to BYPASS
   always_comb begin
      ir_sel = SEL_BYPASS;
`ifdef JTAG_IDCODE_EN
      if (dr.IR == IDCODE_OP) ir_sel = SEL_IDCODE;
`endif
      if (dr.IR == USER_OP) ir_sel = SEL_USER;
   end

   // Select is frozen at capture so IR changes during the scan are ignored
   always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N) sel <= SEL_BYPASS;
      else if (do_capture) sel <= ir_sel;
   end

   // Bypass flop: cleared on capture, one-bit delay line while shifting
   always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N) bypass_sr <= 1'b0;
      else if (do_capture && ir_sel == SEL_BYPASS) bypass_sr <= 1'b0;
      else if (do_shift && sel == SEL_BYPASS) bypass_sr <= dr.SO;
   end

   // USER shift register: parallel load from core, LSB-first shift with SO entering the MSB
   always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N) user_sr <= '0;
      else if (do_capture && ir_sel == SEL_USER) user_sr <= dr.CAPTURE_DATA;
      else if (do_shift && sel == SEL_USER) user_sr <= {dr.SO, user_sr[USER_WIDTH-1:1]};
   end

`ifdef JTAG_IDCODE_EN
   logic [31:0] idcode_sr;

   // IDCODE shift register: reloads the fixed identifier on every capture
   always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N) idcode_sr <= IDCODE_VAL;
      else if (do_capture && ir_sel == SEL_IDCODE) idcode_sr <= IDCODE_VAL;
      else if (do_shift && sel == SEL_IDCODE) idcode_sr <= {dr.SO, idcode_sr[31:1]};
   end
`else
   logic unused_idcode;
   assign unused_idcode = ^{IDCODE_VAL, IDCODE_OP};
`endif

   // Shift counter: restarts on capture and saturates so long scans still read as wrong length
   always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N) bit_cnt <= '0;
      else if (do_capture) bit_cnt <= '0;
      else if (do_shift && bit_cnt != {CNT_WIDTH{1'b1}}) bit_cnt <= bit_cnt + 1'b1;
   end

   // USER update: present the shifted word to core for one cycle and latch length errors
   always_ff @(posedge TCK or negedge TRST_N) begin
      if (!TRST_N) begin
         update_data  <= '0;
         update_valid <= 1'b0;
         len_err      <= 1'b0;
      end else begin
         update_valid <= 1'b0;
         if (do_update && sel == SEL_USER) begin
            update_data  <= user_sr;
            update_valid <= 1'b1;
            if (bit_cnt != CNT_WIDTH'(USER_WIDTH)) len_err <= 1'b1;
         end
      end
   end

   // Serial out is the LSB of whichever register is selected, valid for the whole shift cycle
   always_comb begin
      si = bypass_sr;
      case (sel)
         SEL_USER:   si = user_sr[0];
`ifdef JTAG_IDCODE_EN
         SEL_IDCODE: si = idcode_sr[0];
`endif
         default:    si = bypass_sr;
      endcase
   end

   assign dr.SI           = si;
   assign dr.UPDATE_DATA  = update_data;
   assign dr.UPDATE_VALID = update_valid;
   assign dr.LEN_ERR      = len_err;

endmodule

// File: tb/tb_jtag_dr_chain.sv
// Self-checking bench for jtag_dr_chain. Expected SI bits and expected USER
// updates are queued as stimulus is driven and consumed by a monitor that
// watches the chain outputs. Build with +define+JTAG_IDCODE_EN to cover IDCODE.
module tb_jtag_dr_chain;
   localparam int          USER_WIDTH = 16;
   localparam logic [31:0] IDCODE_VAL = 32'h0000_0001;

   logic TCK = 1'b0;
   logic TRST_N;

   jtag_dr_chain_if #(.IR_WIDTH(6), .USER_WIDTH(USER_WIDTH)) bus ();

   jtag_dr_chain #(
      .IR_WIDTH  (6),
      .USER_WIDTH(USER_WIDTH),
      .CNT_WIDTH (8),
      .IDCODE_OP (6'h01),
      .USER_OP   (6'h02),
      .IDCODE_VAL(IDCODE_VAL)
   ) dut (
      .TCK   (TCK),
      .TRST_N(TRST_N),
      .dr    (bus)
   );

   int                    compared   = 0;
   int                    mismatched = 0;
   logic                  si_q[$];
   logic [USER_WIDTH-1:0] upd_q[$];

   // Free-running test clock
   always #5 TCK = ~TCK;

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Drive one TCK cycle of controls on the falling edge
   task automatic applyStimulus(input logic load, input logic shift, input logic store, input logic so);
      @(negedge TCK);
      bus.LOAD_CHAIN  = load;
      bus.SHIFT_EN    = shift;
      bus.STORE_CHAIN = store;
      bus.SO          = so;
      #2;
   endtask

   // Capture-DR with a given instruction and core capture value
   task automatic captureDr(input logic [5:0] ir, input logic [15:0] cap);
      bus.IR           = ir;
      bus.CAPTURE_DATA = cap;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   // Shift n bits LSB-first, queueing the SI bit expected on each shift cycle
   task automatic shiftDr(input logic [31:0] din, input int n, input logic [31:0] exp_si);
      for (int i = 0; i < n; i++) begin
         si_q.push_back(exp_si[i]);
         applyStimulus(1'b0, 1'b1, 1'b0, din[i]);
      end
   endtask

   // Exit1 -> Update -> idle, optionally expecting a USER update
   task automatic updateDr(input bit expect_upd, input logic [15:0] exp_data);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (expect_upd) upd_q.push_back(exp_data);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Pulse reset asynchronously between clock edges
   task automatic resetDut();
      @(negedge TCK);
      #3 TRST_N = 1'b0;
      @(negedge TCK);
      #3 TRST_N = 1'b1;
   endtask

   // Monitor: compare SI on shift cycles and every UPDATE_VALID pulse against the queues
   initial begin
      forever begin
         @(negedge TCK);
         #1;
         if (TRST_N === 1'b1) begin
            if (bus.SHIFT_EN === 1'b1 && bus.LOAD_CHAIN === 1'b0) begin
               if (si_q.size() > 0) checkOutput("si_bit", 32'(bus.SI), 32'(si_q.pop_front()));
               else checkOutput("si_unexpected_shift", 32'(bus.SHIFT_EN), 32'd0);
            end
            if (bus.UPDATE_VALID !== 1'b0) begin
               if (upd_q.size() > 0) checkOutput("update_data", 32'(bus.UPDATE_DATA), 32'(upd_q.pop_front()));
               else checkOutput("spurious_update_valid", 32'(bus.UPDATE_VALID), 32'd0);
            end
         end
      end
   end

   // Watchdog so a broken DUT or bench can never hang the run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main scenario sequence
   initial begin
      logic [31:0] idcode_exp;
      TRST_N           = 1'b0;
      bus.IR           = '0;
      bus.SO           = 1'b0;
      bus.SHIFT_EN     = 1'b0;
      bus.LOAD_CHAIN   = 1'b0;
      bus.STORE_CHAIN  = 1'b0;
      bus.CAPTURE_DATA = '0;
      #12;
      checkOutput("rst_si", 32'(bus.SI), 32'd0);
      checkOutput("rst_update_data", 32'(bus.UPDATE_DATA), 32'd0);
      checkOutput("rst_update_valid", 32'(bus.UPDATE_VALID), 32'd0);
      checkOutput("rst_len_err", 32'(bus.LEN_ERR), 32'd0);
      @(negedge TCK);
      #3 TRST_N = 1'b1;

      $display("[TB] bypass scan");
      captureDr(6'h3F, 16'hFFFF);
      shiftDr(32'b1101, 4, 32'b1010);
      updateDr(1'b0, 16'h0000);
      checkOutput("bypass_update_data", 32'(bus.UPDATE_DATA), 32'd0);
      checkOutput("bypass_len_err", 32'(bus.LEN_ERR), 32'd0);

      $display("[TB] idcode scan");
`ifdef JTAG_IDCODE_EN
      idcode_exp = IDCODE_VAL;
`else
      idcode_exp = 32'd0;
`endif
      captureDr(6'h01, 16'h0000);
      shiftDr(32'd0, 32, idcode_exp);
      updateDr(1'b0, 16'h0000);
      checkOutput("idcode_len_err", 32'(bus.LEN_ERR), 32'd0);

      $display("[TB] user scan, correct length");
      captureDr(6'h02, 16'hA5C3);
      shiftDr(32'h1234, 16, 32'hA5C3);
      updateDr(1'b1, 16'h1234);
      checkOutput("user_update_data", 32'(bus.UPDATE_DATA), 32'h1234);
      checkOutput("user_update_seen", 32'(upd_q.size()), 32'd0);
      checkOutput("user_len_err", 32'(bus.LEN_ERR), 32'd0);

      $display("[TB] user scan, 15 bits");
      captureDr(6'h02, 16'h5A0F);
      shiftDr(32'h1357, 15, 32'h5A0F);
      updateDr(1'b1, 16'h26AE);
      checkOutput("short_len_err", 32'(bus.LEN_ERR), 32'd1);
      captureDr(6'h02, 16'h0F0F);
      shiftDr(32'hBEEF, 16, 32'h0F0F);
      updateDr(1'b1, 16'hBEEF);
      checkOutput("sticky_update_data", 32'(bus.UPDATE_DATA), 32'hBEEF);
      checkOutput("sticky_len_err", 32'(bus.LEN_ERR), 32'd1);
      resetDut();
      checkOutput("cleared_len_err", 32'(bus.LEN_ERR), 32'd0);

      $display("[TB] zero-length user scan");
      captureDr(6'h02, 16'h4242);
      updateDr(1'b1, 16'h4242);
      checkOutput("zero_len_err", 32'(bus.LEN_ERR), 32'd1);
      resetDut();

      $display("[TB] IR change mid-scan, held update");
      captureDr(6'h02, 16'h00F0);
      shiftDr(32'hC3A5, 8, 32'h00F0);
      bus.IR = 6'h3F;
      shiftDr(32'hC3A5 >> 8, 8, 32'h00F0 >> 8);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      upd_q.push_back(16'hC3A5);
      upd_q.push_back(16'hC3A5);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("irchg_update_seen", 32'(upd_q.size()), 32'd0);
      checkOutput("irchg_len_err", 32'(bus.LEN_ERR), 32'd0);

      $display("[TB] capture priority over shift and update");
      bus.IR           = 6'h02;
      bus.CAPTURE_DATA = 16'h1111;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      shiftDr(32'h0000, 16, 32'h1111);
      updateDr(1'b1, 16'h0000);
      checkOutput("prio_len_err", 32'(bus.LEN_ERR), 32'd0);

      $display("[TB] reset in the middle of a user scan");
      captureDr(6'h02, 16'hFFFF);
      shiftDr(32'h00FF, 8, 32'hFFFF);
      bus.SHIFT_EN = 1'b0;
      #1 TRST_N = 1'b0;
      #1;
      checkOutput("midrst_si", 32'(bus.SI), 32'd0);
      checkOutput("midrst_update_data", 32'(bus.UPDATE_DATA), 32'd0);
      checkOutput("midrst_update_valid", 32'(bus.UPDATE_VALID), 32'd0);
      checkOutput("midrst_len_err", 32'(bus.LEN_ERR), 32'd0);
      @(negedge TCK);
      #3 TRST_N = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("midrst_no_update", 32'(bus.UPDATE_DATA), 32'd0);
      checkOutput("midrst_len_err_after", 32'(bus.LEN_ERR), 32'd0);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("si_queue_drained", 32'(si_q.size()), 32'd0);
      checkOutput("update_queue_drained", 32'(upd_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
